mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbiter and sequencer sharing the CPU's single-port unified memory between the instruction-fetch port and the load/store data port. It sits between the `cpu_top` datapath and the memory macro. Requests are serialised with a fixed three-cycle request/ack handshake. Data accesses have priority, with a bounded-starvation guard so fetch always makes progress.

## Interface
Parameters:
- `ADDR_W`, default 32: address width of all ports.
- `DATA_W`, default 32: data width; must be a multiple of 8.
- `MAX_DM_RUN`, default 4: maximum consecutive data grants while fetch is waiting (≥1).

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `if_req`  in  1  fetch request; held until `if_ack`.
- `if_addr`  in  ADDR_W  fetch address; stable while `if_req`.
- `if_ack`  out  1  one-cycle fetch completion.
- `if_rdata`  out  DATA_W  fetch data; valid only with `if_ack`, else 0.
- `dm_req`  in  1  data request; held until `dm_ack`.
- `dm_we`  in  1  1 = store, 0 = load.
- `dm_addr`  in  ADDR_W  data address.
- `dm_wdata`  in  DATA_W  store data.
- `dm_be`  in  DATA_W/8  store byte enables.
- `dm_ack`  out  1  one-cycle data completion.
- `dm_rdata`  out  DATA_W  load data; valid only with `dm_ack` on a load, else 0.
- `mem_en`  out  1  memory access strobe.
- `mem_we`  out  1  memory write enable.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_be`  out  DATA_W/8  memory byte enables.
- `mem_rdata`  in  DATA_W  memory read data, valid the cycle after `mem_en` with `mem_we`=0.
- `busy`  out  1  high whenever state ≠ IDLE.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - Sample `if_req` and `dm_req`. If neither is high, stay in IDLE.
  - Otherwise pick an owner, register the `mem_*` outputs from the winner and go to ACCESS.
- Arbitration:
  - Only `dm_req` high: grant DM.
  - Only `if_req` high: grant IF.
  - Both high: grant IF if `dm_run == MAX_DM_RUN`, else grant DM.
- `dm_run` counter:
  - On a DM grant: increment, saturating at MAX_DM_RUN, if `if_req` was high; otherwise clear.
  - On an IF grant: clear.
- IF access drives `mem_we`=0 and `mem_be` all ones. `mem_wdata` is don't-care and is driven 0.
- DM access copies `dm_we`, `dm_addr`, `dm_wdata` and `dm_be`.
- ACCESS:
  - `mem_en` is high for exactly this cycle.
  - Next state is RESP; the registered `mem_en`/`mem_we` clear on entry to RESP.
- RESP:
  - Owner's ack is high for one cycle. The owner's rdata is `mem_rdata` (loads and fetches) or 0 (stores).
  - Non-owner ack is 0. Next state is IDLE, unconditionally.
- Requester rule: the requester drops `req` or presents a new transaction the cycle after ack. Because RESP always returns to IDLE, a held `req` is never double-granted.
- A request arriving while the FSM is in ACCESS or RESP waits. It is arbitrated in the next IDLE cycle.
- Request payload is sampled only in IDLE. Changes during ACCESS or RESP have no effect.

## Timing
- Reset: state IDLE; `mem_en`, `mem_we`, `mem_addr`, `mem_wdata`, `mem_be`, `if_ack`, `dm_ack`, `if_rdata`, `dm_rdata`, `busy`, `dm_run` and owner are all 0.
- Latency: `req` sampled high at edge N (IDLE) → `mem_en` high in cycle N+1 → ack high in cycle N+2.
- Throughput: one transaction per 3 cycles minimum.
- `rst` asserted in any state:
  - Abandons the transaction: no ack is issued, `mem_en` is 0 from the next cycle.
  - The requester must re-issue.
- Simultaneous requests in IDLE follow the arbitration rules above. The loser's `req` stays pending and is served in the next IDLE cycle.
- With `MAX_DM_RUN`=4 and both ports continuously requesting, the grant pattern is DM, DM, DM, DM, IF, repeating.

## Test plan
- Reset: hold `rst` 2 cycles with both reqs high → all outputs 0, no `mem_en` during reset; first `mem_en` appears 2 cycles after `rst` falls (IDLE sample, then ACCESS).
- Single fetch: `if_addr`=0x10, memory returns 0x00500093 → `mem_en`/`mem_addr`=0x10 at N+1, `if_ack`=1 and `if_rdata`=0x00500093 at N+2, `busy` high N+1..N+2.
- Store: `dm_we`=1, `dm_addr`=0x200, `dm_wdata`=0xDEADBEEF, `dm_be`=0x3 → `mem_we`=1, `mem_be`=0x3 at N+1; `dm_ack`=1 and `dm_rdata`=0 at N+2.
- Contention: both reqs held for 15 transactions (`MAX_DM_RUN`=4) → grant order DM, DM, DM, DM, IF, repeating three times; each ack is spaced 3 cycles apart.
- Fairness reset: `if_req` low during 3 DM grants, then rises → `dm_run` restarts from 0 at that point; IF is granted after 4 more DM grants.
- Reset mid-op: assert `rst` in ACCESS of a load → no `dm_ack`; the re-issued load completes normally 3 cycles later.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store ports.
// Data accesses win ties, bounded by MAX_DM_RUN consecutive grants while fetch waits.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MAX_DM_RUN = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_ack,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  input  logic [DATA_W/8-1:0] dm_be,
  output logic                dm_ack,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned RUN_W = $clog2(MAX_DM_RUN + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_DM_RUN);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              owner_dm_q, owner_dm_d;
  logic              wr_q, wr_d;
  logic [RUN_W-1:0]  dm_run_q, dm_run_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [BE_W-1:0]   mem_be_q, mem_be_d;
  logic              if_ack_q, if_ack_d;
  logic              dm_ack_q, dm_ack_d;
  logic              busy_q, busy_d;
  logic              grant_dm;

  // Fetch only wins a tie once data has had its full run.
  assign grant_dm = dm_req && !(if_req && (dm_run_q == RUN_MAX));

  always_comb begin
    state_d     = state_q;
    owner_dm_d  = owner_dm_q;
    wr_d        = wr_q;
    dm_run_d    = dm_run_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    if_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (if_req || dm_req) begin
          state_d  = ACCESS;
          mem_en_d = 1'b1;
          if (grant_dm) begin
            owner_dm_d  = 1'b1;
            wr_d        = dm_we;
            mem_we_d    = dm_we;
            mem_addr_d  = dm_addr;
            mem_wdata_d = dm_wdata;
            mem_be_d    = dm_be;
            if (!if_req)                  dm_run_d = '0;
            else if (dm_run_q != RUN_MAX) dm_run_d = dm_run_q + RUN_W'(1);
          end else begin
            owner_dm_d  = 1'b0;
            wr_d        = 1'b0;
            mem_addr_d  = if_addr;
            mem_wdata_d = '0;
            mem_be_d    = '1;
            dm_run_d    = '0;
          end
        end
      end
      ACCESS: begin
        state_d  = RESP;
        if_ack_d = !owner_dm_q;
        dm_ack_d = owner_dm_q;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_dm_q  <= 1'b0;
      wr_q        <= 1'b0;
      dm_run_q    <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_dm_q  <= owner_dm_d;
      wr_q        <= wr_d;
      dm_run_q    <= dm_run_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      if_ack_q    <= if_ack_d;
      dm_ack_q    <= dm_ack_d;
      busy_q      <= busy_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign if_ack    = if_ack_q;
  assign dm_ack    = dm_ack_q;
  assign busy      = busy_q;

  // Memory read data lands in the response cycle, so it is steered straight to the owner.
  assign if_rdata = if_ack_q ? mem_rdata : '0;
  assign dm_rdata = (dm_ack_q && !wr_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int unsigned AW      = 32;
  localparam int unsigned DW      = 32;
  localparam int unsigned MAX_RUN = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ack;
  logic [DW-1:0] if_rdata;
  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [3:0]    dm_be;
  logic          dm_ack;
  logic [DW-1:0] dm_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [3:0]    mem_be;
  logic [DW-1:0] mem_rdata;
  logic          busy;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_DM_RUN(MAX_RUN)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_be(dm_be), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Transaction-level model: cycles since grant (0 = free) plus last granted payload.
  int            m_phase = 0;
  int            m_run   = 0;
  bit            m_dm    = 1'b0;
  bit            m_wr    = 1'b0;
  logic [AW-1:0] m_addr  = '0;
  logic [DW-1:0] m_wdata = '0;
  logic [3:0]    m_be    = '0;

  bit            rd_pend = 1'b0;
  logic [AW-1:0] rd_addr = '0;

  bit grants[$];
  int ack_cyc[$];

  function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
    if (a == 32'h10) return 32'h0050_0093;
    return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_step();
    bit g;
    if (rst) begin
      m_phase = 0; m_run = 0; m_dm = 1'b0; m_wr = 1'b0;
      m_addr = '0; m_wdata = '0; m_be = '0;
    end else if (m_phase == 0) begin
      if (if_req || dm_req) begin
        g = dm_req && !(if_req && m_run == MAX_RUN);
        m_dm = g;
        if (g) begin
          m_wr = dm_we; m_addr = dm_addr; m_wdata = dm_wdata; m_be = dm_be;
          m_run = if_req ? ((m_run < MAX_RUN) ? m_run + 1 : m_run) : 0;
        end else begin
          m_wr = 1'b0; m_addr = if_addr; m_wdata = '0; m_be = 4'hF;
          m_run = 0;
        end
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      m_phase = 2;
    end else begin
      m_phase = 0;
    end
  endtask

  task automatic compare();
    bit e_if_ack, e_dm_ack;
    e_if_ack = (m_phase == 2) && !m_dm;
    e_dm_ack = (m_phase == 2) && m_dm;
    chk("mem_en",    64'(mem_en),    64'(m_phase == 1));
    chk("mem_we",    64'(mem_we),    64'((m_phase == 1) && m_wr));
    chk("mem_addr",  64'(mem_addr),  64'(m_addr));
    chk("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
    chk("mem_be",    64'(mem_be),    64'(m_be));
    chk("if_ack",    64'(if_ack),    64'(e_if_ack));
    chk("dm_ack",    64'(dm_ack),    64'(e_dm_ack));
    chk("if_rdata",  64'(if_rdata),  64'(e_if_ack ? memf(m_addr) : '0));
    chk("dm_rdata",  64'(dm_rdata),  64'((e_dm_ack && !m_wr) ? memf(m_addr) : '0));
    chk("busy",      64'(busy),      64'(m_phase != 0));
  endtask

  // One clock: model consumes the inputs the DUT will sample, memory answers reads, then compare.
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    mem_rdata = rd_pend ? memf(rd_addr) : DW'($urandom);
    @(negedge clk);
    cyc++;
    compare();
    rd_pend = mem_en && !mem_we;
    rd_addr = mem_addr;
  endtask

  task automatic run_collect(input int n);
    for (int i = 0; i < n; i++) begin
      cycle();
      if (dm_ack) begin grants.push_back(1'b1); ack_cyc.push_back(cyc); end
      if (if_ack) begin grants.push_back(1'b0); ack_cyc.push_back(cyc); end
    end
  endtask

  task automatic new_if();
    if_req  = 1'b1;
    if_addr = AW'($urandom) & ~AW'(3);
  endtask

  task automatic new_dm();
    dm_req   = 1'b1;
    dm_we    = 1'($urandom_range(1));
    dm_addr  = AW'($urandom);
    dm_wdata = DW'($urandom);
    dm_be    = 4'($urandom_range(15));
  endtask

  initial begin
    rst = 1'b1; if_req = 1'b1; if_addr = 32'h10;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h40; dm_wdata = '0; dm_be = 4'h0;
    mem_rdata = '0;

    // Reset held two cycles with both requests high.
    cycle(); cycle();
    chk("rst_mem_en", 64'(mem_en), 64'(0));
    chk("rst_busy",   64'(busy),   64'(0));
    rst = 1'b0;
    cycle();
    chk("first_mem_en",   64'(mem_en),   64'(1));
    chk("first_mem_addr", 64'(mem_addr), 64'(32'h40));
    cycle();
    chk("first_dm_ack", 64'(dm_ack), 64'(1));
    dm_req = 1'b0;
    cycle(); cycle(); cycle();
    chk("first_if_ack", 64'(if_ack), 64'(1));
    if_req = 1'b0;
    cycle();

    // Single fetch.
    if_req = 1'b1; if_addr = 32'h10;
    cycle();
    chk("fetch_mem_en",   64'(mem_en),   64'(1));
    chk("fetch_mem_addr", 64'(mem_addr), 64'(32'h10));
    chk("fetch_busy1",    64'(busy),     64'(1));
    cycle();
    chk("fetch_ack",   64'(if_ack),   64'(1));
    chk("fetch_rdata", 64'(if_rdata), 64'(32'h0050_0093));
    chk("fetch_busy2", 64'(busy),     64'(1));
    if_req = 1'b0;
    cycle();
    chk("fetch_idle", 64'(busy), 64'(0));

    // Store.
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h200; dm_wdata = 32'hDEAD_BEEF; dm_be = 4'h3;
    cycle();
    chk("store_we", 64'(mem_we), 64'(1));
    chk("store_be", 64'(mem_be), 64'(4'h3));
    cycle();
    chk("store_ack",   64'(dm_ack),   64'(1));
    chk("store_rdata", 64'(dm_rdata), 64'(0));
    dm_req = 1'b0;
    cycle();

    // Contention: 15 transactions, DM x4 then IF, acks 3 cycles apart.
    dm_we = 1'b0; dm_addr = 32'h300; if_addr = 32'h20;
    grants.delete(); ack_cyc.delete();
    if_req = 1'b1; dm_req = 1'b1;
    run_collect(45);
    chk("cont_count", 64'(grants.size()), 64'(15));
    for (int k = 0; k < grants.size(); k++) begin
      chk($sformatf("cont_grant%0d", k), 64'(grants[k]), 64'((k % 5) != 4));
      if (k > 0) chk($sformatf("cont_gap%0d", k), 64'(ack_cyc[k] - ack_cyc[k-1]), 64'(3));
    end

    // Fairness restart: three DM grants alone, then fetch joins.
    grants.delete(); ack_cyc.delete();
    if_req = 1'b0;
    run_collect(9);
    if_req = 1'b1;
    run_collect(15);
    chk("fair_count", 64'(grants.size()), 64'(8));
    for (int k = 0; k < grants.size(); k++)
      chk($sformatf("fair_grant%0d", k), 64'(grants[k]), 64'(k != 7));

    // Reset during a load's access cycle.
    if_req = 1'b0; dm_req = 1'b0;
    cycle();
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h300;
    cycle();
    chk("midrst_en", 64'(mem_en), 64'(1));
    rst = 1'b1;
    cycle();
    chk("midrst_noack", 64'(dm_ack), 64'(0));
    chk("midrst_en0",   64'(mem_en), 64'(0));
    rst = 1'b0;
    cycle();
    cycle();
    chk("reissue_ack",   64'(dm_ack),   64'(1));
    chk("reissue_rdata", 64'(dm_rdata), 64'(memf(32'h300)));
    dm_req = 1'b0;
    cycle();

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(149) == 0);
      if (dm_ack) begin
        if ($urandom_range(3) != 0) new_dm(); else dm_req = 1'b0;
      end else if (!dm_req && $urandom_range(9) < 5) begin
        new_dm();
      end
      if (if_ack) begin
        if ($urandom_range(3) != 0) new_if(); else if_req = 1'b0;
      end else if (!if_req && $urandom_range(9) < 5) begin
        new_if();
      end
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
